// File: rtl/reg_file_if.sv
// Bus between the issue stage / ROB and the architectural register file.
//
// Handshake: there is no valid/ready pair. rdy_in is a global enable; when it
// is low the register file ignores issue, commit and flush and keeps its
// state. Each of rob_commit, issue_pollute and clear_up is sampled as a
// one-cycle command at a rising clock edge where rdy_in is high. The lookup
// outputs are combinational and always valid. The ROB answers
// get_rob_entryN in the same cycle through readyN/valueN.
interface reg_file_if #(
  parameter int ROB_BIT = 4
);
  logic               rdy_in;
  logic               clear_up;
  logic               issue_pollute;
  logic [4:0]         issue_reg_id;
  logic [ROB_BIT-1:0] issue_rob_entry;
  logic               rob_commit;
  logic [4:0]         commit_rd_reg_id;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic [31:0]        commit_value;
  logic [4:0]         rs1_id;
  logic [4:0]         rs2_id;
  logic               rs1_busy;
  logic [ROB_BIT-1:0] rs1_tag;
  logic [31:0]        rs1_value;
  logic               rs2_busy;
  logic [ROB_BIT-1:0] rs2_tag;
  logic [31:0]        rs2_value;
  logic [ROB_BIT-1:0] get_rob_entry1;
  logic               ready1;
  logic [31:0]        value1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               ready2;
  logic [31:0]        value2;

  // Register file side
  modport slave (
    input  rdy_in, clear_up, issue_pollute, issue_reg_id, issue_rob_entry,
    input  rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
    input  rs1_id, rs2_id, ready1, value1, ready2, value2,
    output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value,
    output get_rob_entry1, get_rob_entry2
  );

  // Issue stage / ROB side
  modport master (
    output rdy_in, clear_up, issue_pollute, issue_reg_id, issue_rob_entry,
    output rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
    output rs1_id, rs2_id, ready1, value1, ready2, value2,
    input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value,
    input  get_rob_entry1, get_rob_entry2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Holds committed values for x1..x31, a busy flag and the ROB entry of the
// newest in-flight producer. Operand lookup is combinational and forwards
// from the same-cycle commit or from the ROB when the producer is done.
module reg_file #(
  parameter int ROB_BIT = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  reg_file_if.slave       bus
);

  logic [31:0]        val_q  [32];
  logic [31:0]        val_d  [32];
  logic [31:0]        busy_q;
  logic [31:0]        busy_d;
  logic [ROB_BIT-1:0] tag_q  [32];
  logic [ROB_BIT-1:0] tag_d  [32];

  // Next state: commit writes the value (clearing busy only on a tag match),
  // then flush or issue overrides busy/tag, so issue wins over commit.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rob_commit && bus.commit_rd_reg_id != 5'd0) begin
      val_d[bus.commit_rd_reg_id] = bus.commit_value;
      if (busy_q[bus.commit_rd_reg_id] &&
          tag_q[bus.commit_rd_reg_id] == bus.commit_rob_entry)
        busy_d[bus.commit_rd_reg_id] = 1'b0;
    end
    if (bus.clear_up) begin
      busy_d = '0;
      for (int i = 0; i < 32; i++) tag_d[i] = '0;
    end else if (bus.issue_pollute && bus.issue_reg_id != 5'd0) begin
      busy_d[bus.issue_reg_id] = 1'b1;
      tag_d[bus.issue_reg_id]  = bus.issue_rob_entry;
    end
  end

  // State registers: async clear, frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (bus.rdy_in) begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

  // Operand 1 lookup: x0, committed value, same-cycle commit, ROB, pending.
  always_comb begin
    bus.get_rob_entry1 = tag_q[bus.rs1_id];
    bus.rs1_busy       = 1'b0;
    bus.rs1_tag        = '0;
    bus.rs1_value      = '0;
    if (bus.rs1_id != 5'd0) begin
      if (!busy_q[bus.rs1_id]) begin
        bus.rs1_value = val_q[bus.rs1_id];
      end else if (bus.rob_commit && bus.commit_rd_reg_id == bus.rs1_id &&
                   bus.commit_rob_entry == tag_q[bus.rs1_id]) begin
        bus.rs1_value = bus.commit_value;
      end else if (bus.ready1) begin
        bus.rs1_value = bus.value1;
      end else begin
        bus.rs1_busy = 1'b1;
        bus.rs1_tag  = tag_q[bus.rs1_id];
      end
    end
  end

  // Operand 2 lookup: same priority as operand 1.
  always_comb begin
    bus.get_rob_entry2 = tag_q[bus.rs2_id];
    bus.rs2_busy       = 1'b0;
    bus.rs2_tag        = '0;
    bus.rs2_value      = '0;
    if (bus.rs2_id != 5'd0) begin
      if (!busy_q[bus.rs2_id]) begin
        bus.rs2_value = val_q[bus.rs2_id];
      end else if (bus.rob_commit && bus.commit_rd_reg_id == bus.rs2_id &&
                   bus.commit_rob_entry == tag_q[bus.rs2_id]) begin
        bus.rs2_value = bus.commit_value;
      end else if (bus.ready2) begin
        bus.rs2_value = bus.value2;
      end else begin
        bus.rs2_busy = 1'b1;
        bus.rs2_tag  = tag_q[bus.rs2_id];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected operand lookups are queued when a
// read is set up and popped when the combinational outputs are sampled.
module tb_reg_file;

  localparam int RB = 4;
  localparam int W  = 1 + RB + 32 + RB;  // {busy, tag, value, get_rob_entry}

  logic clk_in;
  logic rst_in;
  int   vectors;
  int   miscompares;

  logic [W-1:0] exp_q[$];

  reg_file_if #(.ROB_BIT(RB)) bus ();

  reg_file #(.ROB_BIT(RB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Clock and reset
  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_cmds();
    bus.clear_up         = 1'b0;
    bus.issue_pollute    = 1'b0;
    bus.issue_reg_id     = '0;
    bus.issue_rob_entry  = '0;
    bus.rob_commit       = 1'b0;
    bus.commit_rd_reg_id = '0;
    bus.commit_rob_entry = '0;
    bus.commit_value     = '0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [RB-1:0] e);
    bus.issue_pollute   = 1'b1;
    bus.issue_reg_id    = rd;
    bus.issue_rob_entry = e;
  endtask

  task automatic drive_commit(input logic [4:0] rd, input logic [RB-1:0] e,
                              input logic [31:0] v);
    bus.rob_commit       = 1'b1;
    bus.commit_rd_reg_id = rd;
    bus.commit_rob_entry = e;
    bus.commit_value     = v;
  endtask

  task automatic cmp(input string name, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  // Pop both expected operands and compare against the live outputs.
  task automatic sb_check(input string name);
    logic [W-1:0] obs [2];
    logic [W-1:0] e;
    #1;
    obs[0] = {bus.rs1_busy, bus.rs1_tag, bus.rs1_value, bus.get_rob_entry1};
    obs[1] = {bus.rs2_busy, bus.rs2_tag, bus.rs2_value, bus.get_rob_entry2};
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: expected queue empty", name);
      end else begin
        e = exp_q.pop_front();
        cmp($sformatf("%s.rs%0d_busy", name, k + 1), 32'(obs[k][W-1]), 32'(e[W-1]));
        cmp($sformatf("%s.rs%0d_tag", name, k + 1), 32'(obs[k][W-2 -: RB]), 32'(e[W-2 -: RB]));
        cmp($sformatf("%s.rs%0d_value", name, k + 1), obs[k][RB +: 32], e[RB +: 32]);
        cmp($sformatf("%s.get%0d", name, k + 1), 32'(obs[k][RB-1:0]), 32'(e[RB-1:0]));
      end
    end
  endtask

  // Set up a lookup of two registers and queue what each operand must show.
  task automatic read_chk(input string name,
                          input logic [4:0] r1, input logic b1, input logic [RB-1:0] t1,
                          input logic [31:0] v1, input logic [RB-1:0] g1,
                          input logic [4:0] r2, input logic b2, input logic [RB-1:0] t2,
                          input logic [31:0] v2, input logic [RB-1:0] g2);
    bus.rs1_id = r1;
    bus.rs2_id = r2;
    exp_q.push_back({b1, t1, v1, g1});
    exp_q.push_back({b2, t2, v2, g2});
    sb_check(name);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_in      = 1'b1;
    bus.rdy_in  = 1'b1;
    idle_cmds();
    bus.rs1_id  = '0;
    bus.rs2_id  = '0;
    bus.ready1  = 1'b0;
    bus.value1  = '0;
    bus.ready2  = 1'b0;
    bus.value2  = '0;

    // 1. Reset state
    tick();
    tick();
    read_chk("reset", 5'd5, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    rst_in = 1'b0;
    tick();
    read_chk("after_reset", 5'd31, 0, 0, 0, 0, 5'd1, 0, 0, 0, 0);

    // 2. Rename x3 -> entry 2; no same-cycle bypass of the issue
    drive_issue(5'd3, 4'd2);
    read_chk("issue_no_bypass", 5'd3, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0);
    tick();
    idle_cmds();
    read_chk("x3_pending", 5'd3, 1, 2, 0, 2, 5'd3, 1, 2, 0, 2);
    bus.ready1 = 1'b1;
    bus.value1 = 32'h55;
    read_chk("x3_rob_fwd1", 5'd3, 0, 0, 32'h55, 2, 5'd3, 1, 2, 0, 2);
    bus.ready2 = 1'b1;
    bus.value2 = 32'hAB;
    read_chk("x3_rob_fwd2", 5'd3, 0, 0, 32'h55, 2, 5'd3, 0, 0, 32'hAB, 2);
    bus.ready2 = 1'b0;

    // 3. Commit x3 entry 2; commit forward takes priority over ROB forward
    bus.value1 = 32'h66;
    drive_commit(5'd3, 4'd2, 32'hDEAD);
    read_chk("x3_commit_fwd", 5'd3, 0, 0, 32'hDEAD, 2, 5'd3, 0, 0, 32'hDEAD, 2);
    tick();
    idle_cmds();
    bus.ready1 = 1'b0;
    read_chk("x3_committed", 5'd3, 0, 0, 32'hDEAD, 2, 5'd0, 0, 0, 0, 0);

    // 4. Two renames of x4; older commit keeps it busy
    drive_issue(5'd4, 4'd1);
    tick();
    drive_issue(5'd4, 4'd5);
    tick();
    idle_cmds();
    read_chk("x4_newest", 5'd4, 1, 5, 0, 5, 5'd3, 0, 0, 32'hDEAD, 2);
    drive_commit(5'd4, 4'd1, 32'd7);
    read_chk("x4_old_commit_cyc", 5'd4, 1, 5, 0, 5, 5'd0, 0, 0, 0, 0);
    tick();
    idle_cmds();
    read_chk("x4_still_busy", 5'd4, 1, 5, 0, 5, 5'd4, 1, 5, 0, 5);
    drive_commit(5'd4, 4'd5, 32'd9);
    tick();
    idle_cmds();
    read_chk("x4_done", 5'd4, 0, 0, 32'd9, 5, 5'd3, 0, 0, 32'hDEAD, 2);

    // 5. Same-edge issue and commit of x6: issue wins busy/tag
    drive_issue(5'd6, 4'd3);
    drive_commit(5'd6, 4'd0, 32'h11);
    tick();
    idle_cmds();
    read_chk("x6_issue_wins", 5'd6, 1, 3, 0, 3, 5'd6, 1, 3, 0, 3);

    // 6. Flush: drops same-cycle issue, same-cycle commit still writes
    drive_issue(5'd1, 4'd8);
    tick();
    drive_issue(5'd2, 4'd9);
    tick();
    idle_cmds();
    read_chk("x1_x2_busy", 5'd1, 1, 8, 0, 8, 5'd2, 1, 9, 0, 9);
    bus.clear_up = 1'b1;
    drive_issue(5'd7, 4'd10);
    drive_commit(5'd5, 4'd4, 32'h77);
    tick();
    idle_cmds();
    read_chk("flush_x1_x2", 5'd1, 0, 0, 0, 0, 5'd2, 0, 0, 0, 0);
    read_chk("flush_x6_x7", 5'd6, 0, 0, 32'h11, 0, 5'd7, 0, 0, 0, 0);
    read_chk("flush_x3_x4", 5'd3, 0, 0, 32'hDEAD, 0, 5'd4, 0, 0, 32'd9, 0);
    read_chk("flush_x5_commit", 5'd5, 0, 0, 32'h77, 0, 5'd0, 0, 0, 0, 0);

    // x0 ignores issue and commit
    drive_issue(5'd0, 4'd6);
    tick();
    drive_commit(5'd0, 4'd6, 32'h99);
    tick();
    idle_cmds();
    read_chk("x0_ignored", 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0);

    // rdy_in low freezes everything
    bus.rdy_in = 1'b0;
    drive_issue(5'd8, 4'd11);
    drive_commit(5'd3, 4'd0, 32'h1234);
    tick();
    bus.clear_up = 1'b1;
    tick();
    idle_cmds();
    bus.rdy_in = 1'b1;
    read_chk("rdy_freeze", 5'd8, 0, 0, 0, 0, 5'd3, 0, 0, 32'hDEAD, 0);
    drive_issue(5'd9, 4'd12);
    tick();
    bus.rdy_in = 1'b0;
    drive_commit(5'd9, 4'd12, 32'h4321);
    tick();
    idle_cmds();
    bus.rdy_in = 1'b1;
    read_chk("rdy_freeze_busy", 5'd9, 1, 12, 0, 12, 5'd0, 0, 0, 0, 0);

    // Asynchronous reset clears state without a clock edge
    rst_in = 1'b1;
    read_chk("async_reset", 5'd9, 0, 0, 0, 0, 5'd3, 0, 0, 0, 0);
    rst_in = 1'b0;
    tick();
    read_chk("post_async_reset", 5'd4, 0, 0, 0, 0, 5'd6, 0, 0, 0, 0);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
